// File: rtl/machine_mc.sv
// Multi-channel transmission controller: round-robin grants one of N_CH requesters the shared
// DATA/DRDY source, moves up to BURST_LEN words to Y per grant and flags a stalled source (EXC).
module machine_mc #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned N_CH      = 4,
  parameter int unsigned BURST_LEN = 16,
  parameter int unsigned TIMEOUT   = 8,
  localparam int unsigned CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int unsigned CNT_W    = $clog2(BURST_LEN + 1)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              ENA,
  input  logic [N_CH-1:0]   REQ,
  input  logic              DRDY,
  input  logic [DATA_W-1:0] DATA,
  output logic [N_CH-1:0]   ACK,
  output logic [CH_W-1:0]   GNT,
  output logic [DATA_W-1:0] Y,
  output logic              Y_VLD,
  output logic [CNT_W-1:0]  CNT,
  output logic              IDL,
  output logic              EXC
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StXfer, StDone, StExcp} state_e;

  state_e            state_q, state_d;
  logic [N_CH-1:0]   ack_q, ack_d;
  logic [CH_W-1:0]   gnt_q, gnt_d;
  logic [CH_W-1:0]   rr_q, rr_d;
  logic [DATA_W-1:0] y_q, y_d;
  logic              y_vld_q, y_vld_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;

  logic              arb_found;
  logic [CH_W-1:0]   arb_idx;
  logic [CH_W-1:0]   arb_cand;

  // Round-robin search: first requester strictly after the last served channel, wrapping.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    arb_cand  = '0;
    for (int unsigned i = 1; i <= N_CH; i++) begin
      arb_cand = CH_W'((32'(rr_q) + i) % N_CH);
      if (!arb_found && REQ[arb_cand]) begin
        arb_found = 1'b1;
        arb_idx   = arb_cand;
      end
    end
  end

  // Next-state and datapath updates; capture takes priority over end-of-burst and timeout.
  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    gnt_d   = gnt_q;
    rr_d    = rr_q;
    y_d     = y_q;
    y_vld_d = 1'b0;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    unique case (state_q)
      StIdle: begin
        if (ENA && arb_found) begin
          gnt_d   = arb_idx;
          ack_d   = N_CH'(1) << arb_idx;
          cnt_d   = '0;
          tmo_d   = '0;
          state_d = StXfer;
        end
      end
      StXfer: begin
        if (ENA) begin
          if (DRDY) begin
            y_d     = DATA;
            y_vld_d = 1'b1;
            cnt_d   = cnt_q + CNT_W'(1);
            tmo_d   = '0;
          end
          if ((cnt_d == CNT_W'(BURST_LEN)) || !REQ[gnt_q]) begin
            ack_d   = '0;
            rr_d    = gnt_q;
            state_d = StDone;
          end else if (!DRDY) begin
            tmo_d = tmo_q + TMO_W'(1);
            if (tmo_d == TMO_W'(TIMEOUT)) begin
              ack_d   = '0;
              rr_d    = gnt_q;
              state_d = StExcp;
            end
          end
        end
      end
      StDone: begin
        // CNT stays visible for one wind-down cycle.
        state_d = StIdle;
      end
      StExcp: begin
        if (!REQ[gnt_q]) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State register with synchronous reset; rr pointer starts at the last channel so ch0 wins.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= StIdle;
      ack_q   <= '0;
      gnt_q   <= '0;
      rr_q    <= CH_W'(N_CH - 1);
      y_q     <= '0;
      y_vld_q <= 1'b0;
      cnt_q   <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
      y_q     <= y_d;
      y_vld_q <= y_vld_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end

  assign ACK   = ack_q;
  assign GNT   = gnt_q;
  assign Y     = y_q;
  assign Y_VLD = y_vld_q;
  assign CNT   = cnt_q;
  assign IDL   = (state_q == StIdle);
  assign EXC   = (state_q == StExcp);

endmodule

// File: tb/tb_machine_mc.sv
// Bench for machine_mc: directed scenarios plus randomized traffic, every cycle compared
// against a transaction-level reference model of the controller.
module tb_machine_mc;

  localparam int N_CH      = 4;
  localparam int DATA_W    = 8;
  localparam int BURST_LEN = 16;
  localparam int TIMEOUT   = 8;
  localparam int CH_W      = 2;
  localparam int CNT_W     = 5;

  logic              CLK;
  logic              RESET;
  logic              ENA;
  logic [N_CH-1:0]   REQ;
  logic              DRDY;
  logic [DATA_W-1:0] DATA;
  logic [N_CH-1:0]   ACK;
  logic [CH_W-1:0]   GNT;
  logic [DATA_W-1:0] Y;
  logic              Y_VLD;
  logic [CNT_W-1:0]  CNT;
  logic              IDL;
  logic              EXC;

  machine_mc #(
    .DATA_W   (DATA_W),
    .N_CH     (N_CH),
    .BURST_LEN(BURST_LEN),
    .TIMEOUT  (TIMEOUT)
  ) u_dut (
    .CLK  (CLK),
    .RESET(RESET),
    .ENA  (ENA),
    .REQ  (REQ),
    .DRDY (DRDY),
    .DATA (DATA),
    .ACK  (ACK),
    .GNT  (GNT),
    .Y    (Y),
    .Y_VLD(Y_VLD),
    .CNT  (CNT),
    .IDL  (IDL),
    .EXC  (EXC)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_vec;
  int n_err;

  // Reference model: who owns the source, how far the burst has got, how long it has stalled.
  bit        m_busy;    // a channel holds the grant
  bit        m_wrap;    // burst just finished, one wind-down cycle
  bit        m_fault;   // stalled source, waiting for owner to drop its request
  int        m_owner;
  int        m_last;    // last channel served
  int        m_words;
  int        m_stall;
  logic [7:0] m_y;
  bit        m_strobe;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick_next(input int last, input logic [N_CH-1:0] r);
    int c;
    for (int k = 1; k <= N_CH; k++) begin
      c = (last + k) % N_CH;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_busy   = 0;
    m_wrap   = 0;
    m_fault  = 0;
    m_owner  = 0;
    m_last   = N_CH - 1;
    m_words  = 0;
    m_stall  = 0;
    m_y      = 8'h00;
    m_strobe = 0;
  endtask

  // Advance the model across one rising edge with the given inputs.
  task automatic model_step(input bit rst, input bit ena, input logic [N_CH-1:0] req,
                            input bit drdy, input logic [7:0] data);
    bit strobe;
    strobe = 0;
    if (rst) begin
      model_reset();
      return;
    end
    if (m_wrap) begin
      m_wrap = 0;
    end else if (m_fault) begin
      if (!req[m_owner]) m_fault = 0;
    end else if (!m_busy) begin
      if (ena && req != 0) begin
        m_owner = pick_next(m_last, req);
        m_busy  = 1;
        m_words = 0;
        m_stall = 0;
      end
    end else if (ena) begin
      if (drdy) begin
        m_y     = data;
        strobe  = 1;
        m_words = m_words + 1;
        m_stall = 0;
      end
      if (m_words == BURST_LEN || !req[m_owner]) begin
        m_busy = 0;
        m_wrap = 1;
        m_last = m_owner;
      end else if (!drdy) begin
        m_stall = m_stall + 1;
        if (m_stall == TIMEOUT) begin
          m_busy  = 0;
          m_fault = 1;
          m_last  = m_owner;
        end
      end
    end
    m_strobe = strobe;
  endtask

  task automatic compare_all();
    logic [31:0] exp_ack;
    exp_ack = m_busy ? (32'd1 << m_owner) : 32'd0;
    check_eq("ACK",   32'(ACK),   exp_ack);
    check_eq("GNT",   32'(GNT),   32'(m_owner));
    check_eq("Y",     32'(Y),     32'(m_y));
    check_eq("Y_VLD", 32'(Y_VLD), 32'(m_strobe));
    check_eq("CNT",   32'(CNT),   32'(m_words));
    check_eq("IDL",   32'(IDL),   32'(!m_busy && !m_wrap && !m_fault));
    check_eq("EXC",   32'(EXC),   32'(m_fault));
  endtask

  // One clock: check outputs settled from the last edge, then apply inputs for the next edge.
  task automatic step(input bit rst, input bit ena, input logic [N_CH-1:0] req,
                      input bit drdy, input logic [7:0] data);
    @(negedge CLK);
    compare_all();
    RESET = rst;
    ENA   = ena;
    REQ   = req;
    DRDY  = drdy;
    DATA  = data;
    model_step(rst, ena, req, drdy, data);
  endtask

  int strobes;
  int order[4];
  int n_gnt;
  logic [N_CH-1:0] prev_ack;
  bit              r_ena;
  bit              r_drdy;
  logic [N_CH-1:0] r_req;
  int              p_drdy;
  int              p_ena;

  initial begin
    n_vec = 0;
    n_err = 0;
    RESET = 1'b1;
    ENA   = 1'b0;
    REQ   = '0;
    DRDY  = 1'b0;
    DATA  = '0;
    repeat (2) @(posedge CLK);
    model_reset();

    // Single requester, source always ready: one full burst, then re-grant.
    step(1, 1, 4'b0001, 1, 8'hAA);
    strobes = 0;
    for (int i = 0; i < 20; i++) begin
      step(0, 1, 4'b0001, 1, 8'hAA);
      strobes += int'(Y_VLD);
    end
    check_eq("burst_strobes", 32'(strobes), 32'd16);

    // Three requesters held: round-robin order 0,1,3,0.
    step(1, 1, 4'b1011, 1, 8'h5C);
    n_gnt    = 0;
    prev_ack = '0;
    for (int i = 0; i < 65; i++) begin
      step(0, 1, 4'b1011, 1, 8'(i));
      if (prev_ack == 0 && ACK != 0 && n_gnt < 4) begin
        order[n_gnt] = int'(GNT);
        n_gnt++;
      end
      prev_ack = ACK;
    end
    check_eq("rr_grants", 32'(n_gnt), 32'd4);
    check_eq("rr_order0", 32'(order[0]), 32'd0);
    check_eq("rr_order1", 32'(order[1]), 32'd1);
    check_eq("rr_order2", 32'(order[2]), 32'd3);
    check_eq("rr_order3", 32'(order[3]), 32'd0);

    // Requester drops with a word on the same edge: that word still lands.
    step(1, 1, 4'b0100, 0, 8'h00);
    step(0, 1, 4'b0100, 0, 8'h00);
    for (int i = 0; i < 3; i++) step(0, 1, 4'b0100, 1, 8'(8'h10 + i));
    step(0, 1, 4'b0000, 1, 8'h13);
    for (int i = 0; i < 3; i++) step(0, 1, 4'b0000, 0, 8'h00);

    // Stalled source: timeout, held exception, release.
    step(1, 1, 4'b0010, 0, 8'h00);
    step(0, 1, 4'b0010, 0, 8'h00);
    for (int i = 0; i < 8; i++) step(0, 1, 4'b0010, 0, 8'h00);
    for (int i = 0; i < 5; i++) step(0, 1, 4'b0010, 0, 8'h00);
    for (int i = 0; i < 3; i++) step(0, 1, 4'b0000, 0, 8'h00);

    // Stall just short of timeout, pause, then a word on resume.
    step(1, 1, 4'b0001, 0, 8'h00);
    step(0, 1, 4'b0001, 0, 8'h00);
    for (int i = 0; i < 7;  i++) step(0, 1, 4'b0001, 0, 8'h00);
    for (int i = 0; i < 10; i++) step(0, 0, 4'b0001, 0, 8'h00);
    step(0, 1, 4'b0001, 1, 8'h77);
    for (int i = 0; i < 7;  i++) step(0, 1, 4'b0001, 0, 8'h00);

    // Reset mid-burst, then channel 0 must win.
    step(1, 1, 4'b0100, 1, 8'h00);
    for (int i = 0; i < 6; i++) step(0, 1, 4'b0100, 1, 8'(8'h30 + i));
    step(1, 1, 4'b0101, 1, 8'h99);
    for (int i = 0; i < 4; i++) step(0, 1, 4'b0101, 1, 8'h9A);

    // Randomized traffic in segments with varied source readiness and enable duty.
    r_req = 4'b0000;
    for (int seg = 0; seg < 40; seg++) begin
      case ($urandom_range(0, 3))
        0:       p_drdy = 10;
        1:       p_drdy = 50;
        2:       p_drdy = 90;
        default: p_drdy = 100;
      endcase
      p_ena = ($urandom_range(0, 1) != 0) ? 100 : 70;
      for (int i = 0; i < 60; i++) begin
        if ($urandom_range(0, 99) < 6) r_req = 4'($urandom_range(0, 15));
        r_ena  = ($urandom_range(0, 99) < p_ena);
        r_drdy = ($urandom_range(0, 99) < p_drdy);
        step(($urandom_range(0, 999) < 3), r_ena, r_req, r_drdy, 8'($urandom_range(0, 255)));
      end
    end
    step(0, 0, 4'b0000, 0, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
